// File: rtl/dual_core_mem_arbiter_pkg.sv
// dual_core_mem_arbiter_pkg: shared state/owner encodings and default widths
package dual_core_mem_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, PEND, WAIT} state_t;
  typedef enum logic {OWN_C1 = 1'b0, OWN_C2 = 1'b1} owner_t;
  function automatic owner_t other(owner_t o);
    return o == OWN_C1 ? OWN_C2 : OWN_C1;
  endfunction
endpackage

// File: rtl/dual_core_mem_arbiter_if.sv
// dual_core_mem_arbiter_if: one OBI-style req/gnt/rvalid channel; master issues requests
interface dual_core_mem_arbiter_if
  import dual_core_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              req;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              gnt;
  logic              r_valid;
  logic [DATA_W-1:0] rdata;
  modport master (output req, adr, wdata, we, input gnt, r_valid, rdata);
  modport slave (input req, adr, wdata, we, output gnt, r_valid, rdata);
endinterface

// File: rtl/dual_core_mem_arbiter_arb_channel.sv
// arb_channel: 2:1 round-robin, single-outstanding OBI arbiter with zero added latency
module arb_channel
  import dual_core_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [1:0]             req,
  input  logic [1:0][ADDR_W-1:0] adr,
  input  logic [1:0][DATA_W-1:0] wdata,
  input  logic [1:0]             we,
  output logic [1:0]             gnt,
  output logic [1:0]             rvalid,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_adr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_we,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid
);
  state_t state;
  owner_t owner, prio, sel;
  logic   active;
  // Owner is chosen fresh only in IDLE; PEND stays locked to the latched owner
  always_comb begin
    sel       = state != IDLE ? owner : (req[0] & req[1]) ? prio : req[1] ? OWN_C2 : OWN_C1;
    active    = state == IDLE ? |req : state == PEND && req[sel];
    mem_req   = active;
    mem_adr   = active ? adr[sel] : '0;
    mem_wdata = active ? wdata[sel] : '0;
    mem_we    = active & we[sel];
    gnt[0]    = active & mem_gnt & (sel == OWN_C1);
    gnt[1]    = active & mem_gnt & (sel == OWN_C2);
    rvalid[0] = (state == WAIT) & mem_rvalid & (owner == OWN_C1);
    rvalid[1] = (state == WAIT) & mem_rvalid & (owner == OWN_C2);
  end
  // Track ownership and rotate priority only when a grant actually happens
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      owner <= OWN_C1;
      prio  <= OWN_C1;
    end else begin
      case (state)
        IDLE, PEND: begin
          if (!active) state <= IDLE;
          else begin
            owner <= sel;
            state <= mem_gnt ? WAIT : PEND;
            if (mem_gnt) prio <= other(sel);
          end
        end
        WAIT: if (mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/dual_core_mem_arbiter.sv
// dual_core_mem_arbiter: shares instruction and data memory ports between two cores
module dual_core_mem_arbiter
  import dual_core_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    res,
  dual_core_mem_arbiter_if.slave  instr_c1,
  dual_core_mem_arbiter_if.slave  instr_c2,
  dual_core_mem_arbiter_if.master instr_mem,
  dual_core_mem_arbiter_if.slave  data_c1,
  dual_core_mem_arbiter_if.slave  data_c2,
  dual_core_mem_arbiter_if.master data_mem,
  output logic [3:0]              data_be
);
  logic [1:0] i_gnt, i_rvalid, d_gnt, d_rvalid;
  arb_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_instr (
    .clk, .res,
    .req({instr_c2.req, instr_c1.req}), .adr({instr_c2.adr, instr_c1.adr}),
    .wdata('0), .we(2'b00), .gnt(i_gnt), .rvalid(i_rvalid),
    .mem_req(instr_mem.req), .mem_adr(instr_mem.adr), .mem_wdata(instr_mem.wdata),
    .mem_we(instr_mem.we), .mem_gnt(instr_mem.gnt), .mem_rvalid(instr_mem.r_valid)
  );
  arb_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data (
    .clk, .res,
    .req({data_c2.req, data_c1.req}), .adr({data_c2.adr, data_c1.adr}),
    .wdata({data_c2.wdata, data_c1.wdata}), .we({data_c2.we, data_c1.we}),
    .gnt(d_gnt), .rvalid(d_rvalid),
    .mem_req(data_mem.req), .mem_adr(data_mem.adr), .mem_wdata(data_mem.wdata),
    .mem_we(data_mem.we), .mem_gnt(data_mem.gnt), .mem_rvalid(data_mem.r_valid)
  );
  assign instr_c1.gnt     = i_gnt[0];
  assign instr_c2.gnt     = i_gnt[1];
  assign instr_c1.r_valid = i_rvalid[0];
  assign instr_c2.r_valid = i_rvalid[1];
  assign instr_c1.rdata   = instr_mem.rdata;
  assign instr_c2.rdata   = instr_mem.rdata;
  assign data_c1.gnt      = d_gnt[0];
  assign data_c2.gnt      = d_gnt[1];
  assign data_c1.r_valid  = d_rvalid[0];
  assign data_c2.r_valid  = d_rvalid[1];
  assign data_c1.rdata    = data_mem.rdata;
  assign data_c2.rdata    = data_mem.rdata;
  assign data_be          = 4'b1111;
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb_dual_core_mem_arbiter: directed checks of arbitration, stalls, channel independence and reset
module tb_dual_core_mem_arbiter;
  logic       clk = 1'b0;
  logic       res;
  logic [3:0] data_be;
  int         n_tests = 0;
  int         n_fail = 0;
  dual_core_mem_arbiter_if ic1 ();
  dual_core_mem_arbiter_if ic2 ();
  dual_core_mem_arbiter_if im ();
  dual_core_mem_arbiter_if dc1 ();
  dual_core_mem_arbiter_if dc2 ();
  dual_core_mem_arbiter_if dm ();
  dual_core_mem_arbiter dut (
    .clk(clk), .res(res),
    .instr_c1(ic1), .instr_c2(ic2), .instr_mem(im),
    .data_c1(dc1), .data_c2(dc2), .data_mem(dm),
    .data_be(data_be)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    res = 1'b0;
    {ic1.req, ic1.adr, ic1.wdata, ic1.we, ic2.req, ic2.adr, ic2.wdata, ic2.we} = '0;
    {dc1.req, dc1.adr, dc1.wdata, dc1.we, dc2.req, dc2.adr, dc2.wdata, dc2.we} = '0;
    {im.gnt, im.r_valid, im.rdata, dm.gnt, dm.r_valid, dm.rdata} = '0;
    #3;
    check("rst_core_hs", {ic1.gnt, ic2.gnt, ic1.r_valid, ic2.r_valid,
                          dc1.gnt, dc2.gnt, dc1.r_valid, dc2.r_valid}, 8'h00);
    check("rst_mem_req", {im.req, dm.req}, 2'b00);
    check("rst_mem_bus", {dm.adr, dm.wdata, dm.we, im.adr}, '0);
    check("rst_be", data_be, 4'hF);
    repeat (2) @(posedge clk);
    #2 res = 1'b1;
    tick();
    // single instruction fetch by c1
    ic1.req = 1'b1; ic1.adr = 32'h100; im.gnt = 1'b1;
    #2;
    check("t1_gnt", {ic2.gnt, ic1.gnt}, 2'b01);
    check("t1_mem", {im.req, im.adr, im.we}, {1'b1, 32'h100, 1'b0});
    tick();
    ic1.req = 1'b0; im.gnt = 1'b0; im.r_valid = 1'b1; im.rdata = 32'h13;
    #2;
    check("t1_rvalid", {ic2.r_valid, ic1.r_valid}, 2'b01);
    check("t1_rdata", ic1.rdata, 32'h13);
    check("t1_wait_req", im.req, 1'b0);
    tick();
    im.r_valid = 1'b0;
    // contended data reads alternate c1, c2, c1, c2
    dc1.req = 1'b1; dc1.adr = 32'h10; dc2.req = 1'b1; dc2.adr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      dm.gnt = 1'b1; dm.r_valid = 1'b0;
      #2;
      check($sformatf("t2_gnt%0d", k), {dc2.gnt, dc1.gnt}, (k % 2) ? 2'b10 : 2'b01);
      check($sformatf("t2_adr%0d", k), dm.adr, (k % 2) ? 32'h20 : 32'h10);
      tick();
      dm.gnt = 1'b0; dm.r_valid = 1'b1; dm.rdata = 32'h1000 + k;
      #2;
      check($sformatf("t2_wait%0d", k), {dm.req, dc2.gnt, dc1.gnt}, 3'b000);
      check($sformatf("t2_rv%0d", k), {dc2.r_valid, dc1.r_valid}, (k % 2) ? 2'b10 : 2'b01);
      tick();
    end
    dm.r_valid = 1'b0; dc1.req = 1'b0; dc2.req = 1'b0;
    // c2 write stalled 3 cycles while c1 joins; c1 served afterwards
    dc2.req = 1'b1; dc2.adr = 32'h8000_0000; dc2.wdata = 32'hDEADBEEF; dc2.we = 1'b1;
    #2;
    check("t3_c0", {dm.req, dm.adr, dm.we, dc2.gnt}, {1'b1, 32'h8000_0000, 1'b1, 1'b0});
    tick();
    dc1.req = 1'b1; dc1.adr = 32'h44; dc1.we = 1'b0; dm.r_valid = 1'b1;
    #2;
    check("t3_c1", {dm.req, dm.adr, dm.we, dc1.gnt, dc2.gnt}, {1'b1, 32'h8000_0000, 1'b1, 2'b00});
    check("t3_spur_pend", {dc2.r_valid, dc1.r_valid}, 2'b00);
    tick();
    dm.r_valid = 1'b0;
    #2;
    check("t3_c2", {dm.adr, dm.wdata, dm.we}, {32'h8000_0000, 32'hDEADBEEF, 1'b1});
    tick();
    dm.gnt = 1'b1;
    #2;
    check("t3_gnt", {dc2.gnt, dc1.gnt}, 2'b10);
    check("t3_wdata", dm.wdata, 32'hDEADBEEF);
    tick();
    dc2.req = 1'b0; dc2.we = 1'b0; dm.gnt = 1'b0; dm.r_valid = 1'b1;
    #2;
    check("t3_rv", {dc2.r_valid, dc1.r_valid}, 2'b10);
    tick();
    dm.r_valid = 1'b0; dm.gnt = 1'b1;
    #2;
    check("t3_c1_gnt", {dc2.gnt, dc1.gnt, dm.adr, dm.we}, {2'b01, 32'h44, 1'b0});
    tick();
    dc1.req = 1'b0; dm.gnt = 1'b0; dm.r_valid = 1'b1; dm.rdata = 32'hCAFE;
    #2;
    check("t3_c1_rv", {dc2.r_valid, dc1.r_valid, dc1.rdata}, {2'b01, 32'hCAFE});
    tick();
    dm.r_valid = 1'b0;
    // instruction channel in WAIT does not stall the data channel
    ic1.req = 1'b1; ic1.adr = 32'h200; im.gnt = 1'b1;
    #2;
    check("t4_igrant", ic1.gnt, 1'b1);
    tick();
    ic1.req = 1'b0; im.gnt = 1'b0; dc1.req = 1'b1; dc1.adr = 32'h30; dm.gnt = 1'b1;
    #2;
    check("t4_dgrant", {dc1.gnt, dm.adr, im.req}, {1'b1, 32'h30, 1'b0});
    tick();
    dc1.req = 1'b0; dm.gnt = 1'b0; dm.r_valid = 1'b1; dm.rdata = 32'h55;
    #2;
    check("t4_drv", {dc1.r_valid, dc1.rdata, ic1.r_valid}, {1'b1, 32'h55, 1'b0});
    tick();
    dm.r_valid = 1'b0; im.r_valid = 1'b1; im.rdata = 32'h77;
    #2;
    check("t4_irv", {ic1.r_valid, ic1.rdata}, {1'b1, 32'h77});
    tick();
    im.r_valid = 1'b0;
    // reset in WAIT drops the transaction and restores c1 priority
    dc1.req = 1'b1; dc1.adr = 32'h60; dm.gnt = 1'b1;
    #2;
    check("t5_pre_gnt", dc1.gnt, 1'b1);
    tick();
    dc1.req = 1'b0; dm.gnt = 1'b0;
    #2 res = 1'b0;
    #1;
    check("t5_in_rst", {dc1.gnt, dc2.gnt, dc1.r_valid, dc2.r_valid, dm.req}, 5'b0);
    #2 res = 1'b1;
    tick();
    dm.r_valid = 1'b1;
    #2;
    check("t5_stray_rv", {dc2.r_valid, dc1.r_valid}, 2'b00);
    tick();
    dm.r_valid = 1'b0;
    dc1.req = 1'b1; dc1.adr = 32'h70; dc2.req = 1'b1; dc2.adr = 32'h74; dm.gnt = 1'b1;
    #2;
    check("t5_prio_c1", {dc2.gnt, dc1.gnt, dm.adr}, {2'b01, 32'h70});
    tick();
    dc1.req = 1'b0; dc2.req = 1'b0; dm.gnt = 1'b0; dm.r_valid = 1'b1;
    #2;
    check("t5_rv", {dc2.r_valid, dc1.r_valid}, 2'b01);
    tick();
    dm.r_valid = 1'b0;
    // spurious rvalid in IDLE is ignored on both channels
    dm.r_valid = 1'b1; im.r_valid = 1'b1;
    #2;
    check("t6_spur", {dc1.r_valid, dc2.r_valid, ic1.r_valid, ic2.r_valid}, 4'b0);
    check("t6_be", data_be, 4'hF);
    tick();
    dm.r_valid = 1'b0; im.r_valid = 1'b0;
    // owner dropping req in PEND returns to IDLE and frees the channel
    dc2.req = 1'b1; dc2.adr = 32'h90;
    tick();
    dc2.req = 1'b0;
    #2;
    check("t7_drop", dm.req, 1'b0);
    tick();
    dc1.req = 1'b1; dc1.adr = 32'h94; dm.gnt = 1'b1;
    #2;
    check("t7_after", {dc2.gnt, dc1.gnt, dm.adr}, {2'b01, 32'h94});
    tick();
    dc1.req = 1'b0; dm.gnt = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
